queen_job_scheduler: RTL and testbench

- Shares one 8-queens solver between NREQ requesters.
- Round-robin arbitration picks a requester, validates its row-1 seed, and sequences the solver's START/READY handshake.
- Captures the eight row registers, checks them, and returns them on a valid/ready response channel tagged with requester id and error code.
- Recovers a hung solver via timeout and a solver reset pulse.

---
 rtl/queen_job_scheduler_if.sv | 53 +++++
 rtl/queen_job_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_queen_job_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/queen_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// queen_job_scheduler_if
//
// Groups every signal between the shared 8-queens scheduler and its
// environment: requesters, the solver, and the response consumer.
//
//   req        requester -> scheduler  per-requester job request (level)
//   req_seed   requester -> scheduler  row-1 seed per requester, 8 bits each
//   grant      scheduler -> requester  one-cycle one-hot grant pulse
//   busy       scheduler -> requester  high from grant through response accept
//   solv_start scheduler -> solver     START
//   solv_rst   scheduler -> solver     one-cycle reset pulse on timeout
//   solv_seed  scheduler -> solver     latched row-1 seed (reg1Bus)
//   solv_ready solver -> scheduler     READY
//   solv_rows  solver -> scheduler     eight row registers, row k at [8k-1:8k-8]
//   rsp_valid  scheduler -> consumer   response valid
//   rsp_ready  consumer -> scheduler   response accepted
//   rsp_id     scheduler -> consumer   index of the served requester
//   rsp_rows   scheduler -> consumer   captured rows (zero on error)
//   rsp_err    scheduler -> consumer   00 ok, 01 bad seed, 10 timeout, 11 bad result
//
// master: the scheduler side.  slave: the environment side.
// ---------------------------------------------------------------------------
interface queen_job_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_seed;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              solv_start;
    logic              solv_rst;
    logic [7:0]        solv_seed;
    logic              solv_ready;
    logic [63:0]       solv_rows;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [63:0]       rsp_rows;
    logic [1:0]        rsp_err;

    modport master (
        input  req, req_seed, solv_ready, solv_rows, rsp_ready,
        output grant, busy, solv_start, solv_rst, solv_seed,
               rsp_valid, rsp_id, rsp_rows, rsp_err
    );

    modport slave (
        output req, req_seed, solv_ready, solv_rows, rsp_ready,
        input  grant, busy, solv_start, solv_rst, solv_seed,
               rsp_valid, rsp_id, rsp_rows, rsp_err
    );
endinterface

// File: rtl/queen_job_scheduler.sv
// ---------------------------------------------------------------------------
// queen_job_scheduler
//
// Shares one 8-queens solver between NREQ requesters. A round-robin arbiter
// picks a requester, the seed is validated, the solver START/READY handshake
// is sequenced, and the solver's eight rows are checked and returned on a
// valid/ready response channel tagged with the requester id and an error
// code. A solver that never finishes is recovered with a solv_rst pulse.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   queen_job_scheduler_if.master (requests, solver, response)
//
// Parameters:
//   NREQ          number of requesters (2..8)
//   START_CYCLES  cycles solv_start is held high (>= 1)
//   TIMEOUT       max cycles from start release to solv_ready rising again
// ---------------------------------------------------------------------------
module queen_job_scheduler #(
    parameter int NREQ         = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    queen_job_scheduler_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SEED    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RESULT  = 2'b11;

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int STC_W = $clog2(START_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [STC_W-1:0] STC_LAST = STC_W'(START_CYCLES - 1);
    localparam logic [2:0]       ID_LAST  = 3'(NREQ - 1);

    state_t           state;
    logic [2:0]       rr_ptr;
    logic [TMR_W-1:0] timer;
    logic [STC_W-1:0] start_cnt;

    logic [2:0]       winner;
    logic             found;
    logic             rows_ok;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    // A result is accepted only if every row holds exactly one queen and
    // row 1 still carries the seed the job was started with.
    always_comb begin
        rows_ok = (bus.solv_rows[7:0] == bus.solv_seed);
        for (int k = 0; k < 8; k++) begin
            if (!is_onehot(bus.solv_rows[8*k +: 8])) begin
                rows_ok = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            timer          <= '0;
            start_cnt      <= '0;
            bus.grant      <= '0;
            bus.busy       <= 1'b0;
            bus.solv_start <= 1'b0;
            bus.solv_rst   <= 1'b0;
            bus.solv_seed  <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_rows   <= '0;
            bus.rsp_err    <= ERR_OK;
        end else begin
            // Pulse outputs: high for a single cycle when set below.
            bus.grant    <= '0;
            bus.solv_rst <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (found) begin
                        bus.grant     <= NREQ'(1) << winner;
                        bus.solv_seed <= bus.req_seed[8*winner +: 8];
                        bus.rsp_id    <= winner;
                        bus.busy      <= 1'b1;
                        state         <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!is_onehot(bus.solv_seed)) begin
                        // Bad seed: the solver is never started.
                        bus.rsp_err   <= ERR_SEED;
                        bus.rsp_rows  <= '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        bus.solv_start <= 1'b1;
                        start_cnt      <= '0;
                        state          <= S_START;
                    end
                end

                S_START: begin
                    if (start_cnt == STC_LAST) begin
                        bus.solv_start <= 1'b0;
                        timer          <= '0;
                        state          <= S_WAIT_BUSY;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end

                S_WAIT_BUSY, S_WAIT_DONE: begin
                    // Timeout is tested first so it wins over a READY rising
                    // on the same cycle. Leaving here at TIMEOUT is what keeps
                    // the timer saturated rather than wrapping.
                    if (timer == TMR_LAST) begin
                        timer         <= TMR_MAX;
                        bus.solv_rst  <= 1'b1;
                        bus.rsp_err   <= ERR_TIMEOUT;
                        bus.rsp_rows  <= '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == S_WAIT_BUSY && !bus.solv_ready) begin
                            state <= S_WAIT_DONE;
                        end else if (state == S_WAIT_DONE && bus.solv_ready) begin
                            state <= S_CAPTURE;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (rows_ok) begin
                        bus.rsp_rows <= bus.solv_rows;
                        bus.rsp_err  <= ERR_OK;
                    end else begin
                        bus.rsp_rows <= '0;
                        bus.rsp_err  <= ERR_RESULT;
                    end
                    bus.rsp_valid <= 1'b1;
                    state         <= S_RESP;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == ID_LAST) ? 3'd0 : bus.rsp_id + 3'd1;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queen_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_queen_job_scheduler
//
// Self-checking bench for queen_job_scheduler. A behavioural solver model
// answers START/READY; a negedge monitor pushes the expected response into a
// scoreboard queue on every grant and pops/compares it when the response is
// accepted.
// ---------------------------------------------------------------------------
module tb_queen_job_scheduler;

    localparam int NREQ         = 4;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 50;
    localparam int OK_LATENCY   = 8;   // 1 + START_CYCLES + S(=3) + 1 + 1

    typedef enum {M_OK, M_SLOW, M_HANG, M_BAD} mode_t;

    typedef struct {
        logic [2:0]  id;
        logic [1:0]  err;
        logic [63:0] rows;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    mode_t solv_mode;

    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  sb[$];

    queen_job_scheduler_if #(.NREQ(NREQ)) bus ();

    queen_job_scheduler #(
        .NREQ        (NREQ),
        .START_CYCLES(START_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Board returned by the solver model: row 1 is the seed, other rows are
    // one-hot; the BAD mode corrupts row 4.
    function automatic logic [63:0] board_of(input logic [7:0] seed, input mode_t m);
        logic [63:0] b;
        b[7:0] = seed;
        for (int k = 1; k < 8; k++) begin
            b[8*k +: 8] = 8'(1 << ((k * 3) % 8));
        end
        if (m == M_BAD) begin
            b[31:24] = 8'h0C;
        end
        return b;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            int j = (p + i) % NREQ;
            if (r[j]) return j;
        end
        return p;
    endfunction

    // ---------------- solver model ----------------
    initial begin
        int          phase;
        int          cnt;
        logic [7:0]  lat_seed;
        phase          = 0;
        cnt            = 0;
        lat_seed       = '0;
        bus.solv_ready = 1'b1;
        bus.solv_rows  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || bus.solv_rst) begin
                bus.solv_ready = 1'b1;
                phase          = 0;
            end else begin
                case (phase)
                    0: if (bus.solv_start) begin
                        phase    = 1;
                        lat_seed = bus.solv_seed;
                    end
                    1: if (!bus.solv_start) begin
                        phase = 2;
                        cnt   = 0;
                    end
                    default: begin
                        cnt++;
                        if (cnt == 1) bus.solv_ready = 1'b0;
                        if (solv_mode != M_HANG && cnt == ((solv_mode == M_SLOW) ? 20 : 3)) begin
                            bus.solv_rows  = board_of(lat_seed, solv_mode);
                            bus.solv_ready = 1'b1;
                            phase          = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int                cyc = 0;
        int                tb_ptr = 0;
        int                grant_cyc = 0;
        int                rel_cyc = 0;
        int                start_cnt = 0;
        int                rst_cnt = 0;
        bit                acc_pend = 0;
        logic              prev_valid = 0;
        logic              prev_ready = 0;
        logic              prev_start = 0;
        logic              prev_busy = 0;
        logic [NREQ-1:0]   prev_req = '0;
        logic [8*NREQ-1:0] prev_seed = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                tb_ptr     = 0;
                acc_pend   = 0;
                prev_valid = 0;
                prev_ready = 0;
                prev_start = 0;
                prev_busy  = 0;
                prev_req   = bus.req;
                prev_seed  = bus.req_seed;
                continue;
            end

            if (acc_pend) begin
                check("post_accept_valid", 64'(bus.rsp_valid), 64'd0);
                check("post_accept_busy", 64'(bus.busy), 64'd0);
                acc_pend = 0;
            end

            if (bus.grant != '0) begin
                int         w;
                logic [7:0] seed;
                exp_t       e;
                w = rr_pick(prev_req, tb_ptr);
                check("grant", 64'(bus.grant), 64'(1) << w);
                check("grant_while_busy", 64'(prev_busy), 64'd0);
                seed = prev_seed[8*w +: 8];
                e.id = 3'(w);
                if (!onehot(seed))            e.err = 2'b01;
                else if (solv_mode == M_HANG) e.err = 2'b10;
                else if (solv_mode == M_BAD)  e.err = 2'b11;
                else                          e.err = 2'b00;
                e.rows = (e.err == 2'b00) ? board_of(seed, M_OK) : 64'd0;
                sb.push_back(e);
                grant_cyc = cyc;
                start_cnt = 0;
                rst_cnt   = 0;
            end

            if (bus.solv_start) start_cnt++;
            if (prev_start && !bus.solv_start) rel_cyc = cyc;
            if (bus.solv_rst) begin
                rst_cnt++;
                check("timeout_delay", 64'(cyc - rel_cyc), 64'(TIMEOUT));
            end

            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            end

            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb[0];
                    if (!prev_valid && e.err == 2'b00) begin
                        check("latency", 64'(cyc - grant_cyc), 64'(OK_LATENCY));
                    end
                    check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    check("rsp_rows", bus.rsp_rows, e.rows);
                    if (bus.rsp_ready) begin
                        check("start_cycles", 64'(start_cnt),
                              (e.err == 2'b01) ? 64'd0 : 64'(START_CYCLES));
                        check("solv_rst_pulses", 64'(rst_cnt),
                              (e.err == 2'b10) ? 64'd1 : 64'd0);
                        tb_ptr   = (int'(e.id) == NREQ - 1) ? 0 : int'(e.id) + 1;
                        acc_pend = 1;
                        void'(sb.pop_front());
                    end
                end
            end

            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_start = bus.solv_start;
            prev_busy  = bus.busy;
            prev_req   = bus.req;
            prev_seed  = bus.req_seed;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},      64'(bus.grant),      64'd0);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
        check({tag, "_solv_start"}, 64'(bus.solv_start), 64'd0);
        check({tag, "_solv_rst"},   64'(bus.solv_rst),   64'd0);
        check({tag, "_solv_seed"},  64'(bus.solv_seed),  64'd0);
        check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
        check({tag, "_rsp_id"},     64'(bus.rsp_id),     64'd0);
        check({tag, "_rsp_rows"},   bus.rsp_rows,        64'd0);
        check({tag, "_rsp_err"},    64'(bus.rsp_err),    64'd0);
    endtask

    task automatic wait_grant(input int id);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (bus.grant[id]) return;
        end
        check("grant_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) return;
        end
        check("idle_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic run_job(input int id, input logic [7:0] seed, input mode_t m);
        solv_mode              = m;
        bus.req_seed[8*id +: 8] = seed;
        bus.req[id]            = 1'b1;
        wait_grant(id);
        bus.req[id] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int n_grants;
        rst           = 1'b1;
        solv_mode     = M_OK;
        bus.req       = '0;
        bus.req_seed  = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Single valid job.
        run_job(0, 8'h02, M_OK);

        // Round robin with all requests held.
        bus.req_seed = {8'h20, 8'h10, 8'h08, 8'h04};
        solv_mode    = M_OK;
        bus.req      = '1;
        n_grants     = 0;
        for (int c = 0; c < 200 && n_grants < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.grant != '0) n_grants++;
        end
        bus.req = '0;
        check("rr_grant_count", 64'(n_grants), 64'd5);
        wait_idle();

        // Bad seeds: two bits set, then zero.
        run_job(2, 8'h06, M_OK);
        run_job(1, 8'h00, M_OK);

        // Hung solver -> timeout.
        run_job(3, 8'h80, M_HANG);

        // Solver returns a board with a non one-hot row.
        run_job(0, 8'h01, M_BAD);

        // Backpressure on the response channel.
        bus.rsp_ready         = 1'b0;
        solv_mode             = M_OK;
        bus.req_seed[31:24]   = 8'h20;
        bus.req[3]            = 1'b1;
        wait_grant(3);
        bus.req[3] = 1'b0;
        for (int c = 0; c < 50 && !bus.rsp_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("bp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Async reset while the solver is busy, with req[1] pending.
        solv_mode           = M_SLOW;
        bus.req_seed[7:0]   = 8'h08;
        bus.req[0]          = 1'b1;
        wait_grant(0);
        bus.req[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        check("pre_reset_solver_busy", 64'(bus.solv_ready), 64'd0);
        bus.req_seed[15:8] = 8'h40;
        bus.req[1]         = 1'b1;
        solv_mode          = M_OK;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grant(1);
        bus.req[1] = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
